ahb_sram_slave: RTL and testbench
=================================

# ahb_sram_slave

- Word-organised SRAM slave on the AHB bus, downstream of the ALU/register-file AHB master.
- Consumes the master's address/control/write-data outputs; returns HRDATA, HREADY and HRESP.
- Pipelined AHB address/data phases, byte/halfword/word writes, optional programmable wait states.
- Two-cycle ERROR response on misaligned, oversized or out-of-range transfers.

## Interface
Parameters:
- ADDR_WIDTH, 8, word-index width; memory depth = 2^ADDR_WIDTH 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be word-aligned.
- WAIT_CYCLES, 1, wait states per OKAY data phase (only with WAIT_STATE_EN); 0..15.

Ports (one clock; reset is asynchronous and active-high):
- HCLK  in  1  bus clock, all state on rising edge
- HRESET  in  1  asynchronous, active-high reset
- HSEL  in  1  slave select; tie high in single-slave systems
- HADDR  in  32  byte address (address phase)
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- HWRITE  in  1  1 = write
- HSIZE  in  3  0 byte, 1 halfword, 2 word; others illegal
- HBURST  in  3  accepted, not decoded
- HWDATA  in  32  write data (data phase)
- HRDATA  out  32  read data (data phase)
- HREADY  out  1  transfer done / address phase accepted
- HRESP  out  1  0 OKAY, 1 ERROR

## Operation
- Address phase accepted on a rising edge when HREADY=1, HSEL=1 and HTRANS[1]=1 (NONSEQ/SEQ). Capture into addr_q, write_q, size_q, lane_q = HADDR[1:0].
- IDLE, BUSY or HSEL=0 with HREADY=1: no access; next cycle OKAY, zero wait.
- Transfer is illegal if any of the following hold:
  - HSIZE > 2;
  - HSIZE=1 with HADDR[0]=1;
  - HSIZE=2 with HADDR[1:0]≠0;
  - HADDR < BASE_ADDR;
  - HADDR − BASE_ADDR ≥ 4·2^ADDR_WIDTH.
- Legal transfers go to S_WAIT or S_DATA; illegal ones go to S_ERR1. Illegal transfers never write memory.
- States:
  - S_IDLE: HREADY=1, HRESP=0.
  - S_WAIT: HREADY=0, down-counter from WAIT_CYCLES; moves to S_DATA when the count reaches 1.
  - S_DATA: HREADY=1, HRESP=0. Write commits on this edge; read data is valid this cycle.
  - S_ERR1: HREADY=0, HRESP=1.
  - S_ERR2: HREADY=1, HRESP=1.
- From S_DATA or S_ERR2, the next state depends on the address phase sampled at the same edge: S_WAIT or S_DATA for a new legal transfer, S_ERR1 for an illegal one, else S_IDLE.
- Addresses presented while HREADY=0 are ignored; the master holds them stable.
- Write byte lanes are little-endian: byte n ↔ HWDATA[8n+7:8n].
  - Byte: writes lane lane_q.
  - Halfword: writes lanes lane_q and lane_q+1.
  - Word: writes all four lanes.
  - Unselected bytes are preserved.
- Read: HRDATA = mem[addr_q] (full word, every size) in S_DATA of a read; 32'h0 in all other states.
- Memory contents are not reset.

## Timing
- Reset values: HREADY=1, HRESP=0, HRDATA=0, state S_IDLE, wait counter 0.
- Reset asserted mid-transfer aborts it; a pending write is not committed.
- Zero-wait latency: address phase at edge N; data phase in cycle N→N+1; write commits at edge N+1.
- Back-to-back write then read of the same word: the read returns the new data. The write commits at the edge that registers the read address, and the read is combinational from the array.
- Wait-state latency: data phase lasts WAIT_CYCLES+1 cycles.
- ERROR: always exactly 2 cycles, never wait-extended. HRESP=1 in both; HREADY=0 then 1.
- Pipelined back-to-back transfers sustain one transfer per (WAIT_CYCLES+1) cycles.

## Configuration
- Macro: AHB_SRAM_WAIT_STATE_EN.
- Defined: every OKAY read/write data phase is extended by WAIT_CYCLES cycles of HREADY=0. WAIT_CYCLES=0 behaves as undefined.
- Undefined: the wait counter and S_WAIT are compiled out; all OKAY transfers are zero-wait.
- ERROR timing is identical in both builds.

## Test plan
- Reset: HRESET=1 mid read data phase → HREADY=1, HRESP=0, HRDATA=0 immediately; after release, a NONSEQ read completes normally.
- Word write then read: write 32'hDEADBEEF to BASE+0x10, then an immediate read of 0x10 → HRDATA=32'hDEADBEEF in the next data phase with HRESP=0.
- Byte/halfword merge: word 0x11223344 at 0x20; byte write 0xAA to 0x22 (HWDATA=32'h00AA0000); halfword write 0xBEEF to 0x20 → read 0x20 = 32'h11AABEEF.
- Errors, each → HREADY 0 then 1, HRESP 1,1, memory unchanged:
  - halfword write at 0x21;
  - HSIZE=3;
  - HADDR=BASE+0x400 with ADDR_WIDTH=8.
- Wait states (macro defined, WAIT_CYCLES=2): 4-beat SEQ read burst → each beat shows 2 HREADY=0 cycles then data; total 12 cycles; burst addresses correct.
- BUSY/IDLE: NONSEQ, BUSY, SEQ sequence → BUSY slot gives OKAY zero-wait, no memory access; the SEQ beat completes normally.

Source files
------------

// File: rtl/ahb_sram_slave_if.sv
// AHB-lite bus bundle between the ALU/register-file master and the SRAM slave.
interface ahb_sram_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// Word-organised AHB SRAM slave: pipelined address/data phases, byte-lane writes,
// two-cycle ERROR on illegal transfers. Define AHB_SRAM_WAIT_STATE_EN for wait states.
module ahb_sram_slave #(
    parameter int          ADDR_WIDTH  = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1
) (
    input logic              HCLK,
    input logic              HRESET,
    ahb_sram_slave_if.slave  bus
);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    // Window size in bytes; a borrow in the offset subtraction also lands above it.
    localparam logic [32:0] SPAN = 33'(4) << ADDR_WIDTH;

`ifdef AHB_SRAM_WAIT_STATE_EN
    localparam state_t OK_NEXT = (WAIT_CYCLES != 0) ? S_WAIT : S_DATA;
`else
    localparam state_t OK_NEXT = S_DATA;
`endif

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [2:0]            size_q;
    logic [1:0]            lane_q;
    logic [31:0]           mem [2**ADDR_WIDTH];

    logic [32:0] offset;
    logic        accept, illegal;
    logic [3:0]  be;

    assign offset = {1'b0, bus.HADDR} - {1'b0, BASE_ADDR};

    assign illegal = (bus.HSIZE > 3'd2)
                  || (bus.HSIZE == 3'd1 && bus.HADDR[0])
                  || (bus.HSIZE == 3'd2 && bus.HADDR[1:0] != 2'b00)
                  || (offset >= SPAN);

    assign bus.HREADY = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
    assign bus.HRESP  = (state == S_ERR1) || (state == S_ERR2);
    assign bus.HRDATA = (state == S_DATA && !write_q) ? mem[addr_q] : 32'h0;

    assign accept = bus.HREADY && bus.HSEL && bus.HTRANS[1];

`ifdef AHB_SRAM_WAIT_STATE_EN
    logic [3:0] wcnt;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET)                 wcnt <= 4'd0;
        else if (accept && !illegal) wcnt <= 4'(WAIT_CYCLES);
        else if (state == S_WAIT)   wcnt <= wcnt - 4'd1;
    end
`endif

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
`ifdef AHB_SRAM_WAIT_STATE_EN
            S_WAIT: if (wcnt == 4'd1) state_nxt = S_DATA;
`endif
            S_ERR1: state_nxt = S_ERR2;
            // IDLE, DATA and ERR2 all sample the next address phase.
            default: begin
                if (accept) state_nxt = illegal ? S_ERR1 : OK_NEXT;
                else        state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 3'd0;
            lane_q  <= 2'd0;
        end else if (accept) begin
            addr_q  <= offset[ADDR_WIDTH+1:2];
            write_q <= bus.HWRITE;
            size_q  <= bus.HSIZE;
            lane_q  <= bus.HADDR[1:0];
        end
    end

    always_comb begin
        be = 4'hF;
        case (size_q[1:0])
            2'd0:    be = 4'b0001 << lane_q;
            2'd1:    be = 4'b0011 << lane_q;
            default: be = 4'hF;
        endcase
    end

    // Array is not reset; an aborted data phase never reaches S_DATA, so never commits.
    always_ff @(posedge HCLK) begin
        if (state == S_DATA && write_q) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[addr_q][8*b +: 8] <= bus.HWDATA[8*b +: 8];
        end
    end

    logic unused_ok;
    assign unused_ok = ^{bus.HBURST, size_q[2]};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: pipelined single transfers, lane merges, errors,
// bursts, BUSY slots and reset abort. Wait expectations follow AHB_SRAM_WAIT_STATE_EN.
module tb_ahb_sram_slave;

    localparam logic [31:0] B = 32'h0000_1000;
`ifdef AHB_SRAM_WAIT_STATE_EN
    localparam int EXP_W = 2;
`else
    localparam int EXP_W = 0;
`endif

    logic HCLK = 1'b0;
    logic HRESET;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    ahb_sram_slave_if bus ();

    ahb_sram_slave #(.ADDR_WIDTH(8), .BASE_ADDR(B), .WAIT_CYCLES(2)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge HCLK);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one address phase, then follows its data phase to completion. Returns in the
    // last data-phase cycle (HREADY=1), so the next call pipelines its address phase there.
    task automatic xfer(input string tag, input logic [1:0] tr, input logic wr,
                        input logic [2:0] sz, input logic [31:0] off, input logic [31:0] wd,
                        input logic err, input logic [31:0] exp_rd);
        int n;
        bus.HSEL = 1'b1; bus.HTRANS = tr; bus.HWRITE = wr; bus.HSIZE = sz; bus.HADDR = B + off;
        tick();
        bus.HTRANS = 2'b00;
        bus.HWDATA = wd;
        if (err) begin
            chk({tag, ".rdy1"},  32'(bus.HREADY), 32'd0);
            chk({tag, ".resp1"}, 32'(bus.HRESP),  32'd1);
            tick();
            chk({tag, ".rdy2"},  32'(bus.HREADY), 32'd1);
            chk({tag, ".resp2"}, 32'(bus.HRESP),  32'd1);
        end else begin
            n = 0;
            while (!bus.HREADY && n < 20) begin
                tick();
                n++;
            end
            chk({tag, ".waits"}, 32'(n), 32'(EXP_W));
            chk({tag, ".resp"},  32'(bus.HRESP), 32'd0);
            if (!wr) chk({tag, ".rdata"}, bus.HRDATA, exp_rd);
        end
    endtask

    initial begin
        int t0;
        HRESET = 1'b1;
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HSIZE = 3'd0;
        bus.HADDR = 32'h0; bus.HBURST = 3'd0; bus.HWDATA = 32'h0;
        #3;
        chk("rst.ready", 32'(bus.HREADY), 32'd1);
        chk("rst.resp",  32'(bus.HRESP),  32'd0);
        chk("rst.rdata", bus.HRDATA,      32'h0);
        @(negedge HCLK);
        HRESET = 1'b0;
        tick();

        // Back-to-back write then read of the same word
        xfer("w10", 2'b10, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
        xfer("r10", 2'b10, 1'b0, 3'd2, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF);

        // Byte/halfword merges
        xfer("w20",  2'b10, 1'b1, 3'd2, 32'h20, 32'h11223344, 1'b0, 32'h0);
        xfer("b22",  2'b10, 1'b1, 3'd0, 32'h22, 32'h00AA0000, 1'b0, 32'h0);
        xfer("h20",  2'b10, 1'b1, 3'd1, 32'h20, 32'h0000BEEF, 1'b0, 32'h0);
        xfer("r20",  2'b10, 1'b0, 3'd2, 32'h20, 32'h0,        1'b0, 32'h11AABEEF);
        xfer("w24",  2'b10, 1'b1, 3'd2, 32'h24, 32'hCAFEF00D, 1'b0, 32'h0);
        xfer("h26",  2'b10, 1'b1, 3'd1, 32'h26, 32'h12340000, 1'b0, 32'h0);
        xfer("b25",  2'b10, 1'b1, 3'd0, 32'h25, 32'h00009900, 1'b0, 32'h0);
        xfer("r24",  2'b10, 1'b0, 3'd0, 32'h27, 32'h0,        1'b0, 32'h1234990D);

        // Illegal transfers, pipelined back to back; none may touch memory
        xfer("e_h21",  2'b10, 1'b1, 3'd1, 32'h21,         32'hFFFFFFFF, 1'b1, 32'h0);
        xfer("e_sz3",  2'b10, 1'b1, 3'd3, 32'h20,         32'hFFFFFFFF, 1'b1, 32'h0);
        xfer("e_w22",  2'b10, 1'b1, 3'd2, 32'h22,         32'hFFFFFFFF, 1'b1, 32'h0);
        xfer("e_400",  2'b10, 1'b1, 3'd2, 32'h400,        32'hFFFFFFFF, 1'b1, 32'h0);
        xfer("e_low",  2'b10, 1'b1, 3'd2, 32'hFFFFFFFC,   32'hFFFFFFFF, 1'b1, 32'h0);
        xfer("e_rd",   2'b10, 1'b0, 3'd2, 32'h401,        32'h0,        1'b1, 32'h0);
        xfer("r20e",   2'b10, 1'b0, 3'd2, 32'h20,         32'h0,        1'b0, 32'h11AABEEF);

        // Last word of the window
        xfer("w3fc", 2'b10, 1'b1, 3'd2, 32'h3FC, 32'h5A5AA5A5, 1'b0, 32'h0);
        xfer("r3fc", 2'b10, 1'b0, 3'd2, 32'h3FC, 32'h0,        1'b0, 32'h5A5AA5A5);

        // 4-beat bursts: fill then read back, checking sustained throughput
        for (int i = 0; i < 4; i++)
            xfer("bw", (i == 0) ? 2'b10 : 2'b11, 1'b1, 3'd2, 32'h30 + 32'(4*i),
                 32'hB000_0000 + 32'(i), 1'b0, 32'h0);
        t0 = cyc;
        for (int i = 0; i < 4; i++)
            xfer("br", (i == 0) ? 2'b10 : 2'b11, 1'b0, 3'd2, 32'h30 + 32'(4*i),
                 32'h0, 1'b0, 32'hB000_0000 + 32'(i));
        chk("burst.cycles", 32'(cyc - t0), 32'(4*(EXP_W+1)));

        // NONSEQ, BUSY (dressed as a write), SEQ
        xfer("bz0", 2'b10, 1'b0, 3'd2, 32'h30, 32'h0, 1'b0, 32'hB000_0000);
        bus.HSEL = 1'b1; bus.HTRANS = 2'b01; bus.HWRITE = 1'b1; bus.HSIZE = 3'd2; bus.HADDR = B + 32'h34;
        tick();
        bus.HWDATA = 32'hFFFFFFFF;
        chk("busy.ready", 32'(bus.HREADY), 32'd1);
        chk("busy.resp",  32'(bus.HRESP),  32'd0);
        chk("busy.rdata", bus.HRDATA,      32'h0);
        xfer("bz1", 2'b11, 1'b0, 3'd2, 32'h34, 32'h0, 1'b0, 32'hB000_0001);
        bus.HTRANS = 2'b00;
        tick();

        // Reset in the middle of a read data phase
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HSIZE = 3'd2; bus.HADDR = B + 32'h10;
        tick();
        bus.HTRANS = 2'b00;
        chk("mid.rdata", bus.HRDATA, (EXP_W == 0) ? 32'hDEADBEEF : 32'h0);
        #1 HRESET = 1'b1;
        #1;
        chk("mid.ready", 32'(bus.HREADY), 32'd1);
        chk("mid.resp",  32'(bus.HRESP),  32'd0);
        chk("mid.rdata0", bus.HRDATA,     32'h0);
        @(negedge HCLK);
        HRESET = 1'b0;
        tick();
        xfer("post", 2'b10, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

        // Reset during a write data phase must drop the write
        xfer("aw", 2'b10, 1'b1, 3'd2, 32'h10, 32'h0BADF00D, 1'b0, 32'h0);
        #1 HRESET = 1'b1;
        @(negedge HCLK);
        HRESET = 1'b0;
        bus.HTRANS = 2'b00;
        tick();
        xfer("ar", 2'b10, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
        bus.HTRANS = 2'b00;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
